sram_lsu_ctrl: RTL and testbench
================================

// Module: sram_lsu_ctrl
// PURPOSE
//  Load/store unit front-end between the RV32 core's MEM stage and the external 16-bit async SRAM.
//  Accepts one byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW request by valid/ready and splits it into 1..2 halfword beats.
//  Each beat is stretched by configurable wait states. Returns sign/zero-extended load data or an error via a one-cycle response.
//  Replaces the single-cycle combinational SRAM path; the core stalls on ~req_ready/~rsp_valid.
// PARAMETERS
//  ADDR_W       20  SRAM halfword address width (byte address = ADDR_W+1 bits)
//  SRAM_DW      16  SRAM data width; only 16 supported, elaborate-time error otherwise
//  XLEN         32  core data width
//  WAIT_CYCLES  0   extra cycles each beat is held (beat length = WAIT_CYCLES+1)
// PORTS
//  i_clk        in   1         clock
//  i_rst_n      in   1         synchronous active-low reset
//  i_req_valid  in   1         request present
//  o_req_ready  out  1         1 only in IDLE
//  i_req_we     in   1         1=store, 0=load
//  i_req_funct3 in   3         RV32 load/store funct3
//  i_req_addr   in   ADDR_W+1  byte address
//  i_req_wdata  in   XLEN      store data (low bits used for SB/SH)
//  o_rsp_valid  out  1         one-cycle completion pulse
//  o_rsp_rdata  out  XLEN      extended load data; 0 for stores/errors
//  o_rsp_err    out  1         misaligned or illegal funct3; valid with o_rsp_valid
//  o_SRAM_ADDR  out  ADDR_W    halfword address
//  io_SRAM_DQ   inout SRAM_DW  data; driven only during write beats, else 'z
//  o_SRAM_CE_N / o_SRAM_OE_N / o_SRAM_WE_N / o_SRAM_LB_N / o_SRAM_UB_N  out 1 each  active-low controls
// BEHAVIOUR
//  Clocking: one clock, i_clk. Reset: synchronous, active-low, i_rst_n. No other clock or reset.
//  Reset: state=IDLE; o_req_ready=1; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
//    All SRAM controls are 1 (CE/OE/WE/LB/UB_N); o_SRAM_ADDR=0; DQ is 'z.
//  FSM IDLE -> BEAT -> RESP -> IDLE:
//    Accept when i_req_valid&&o_req_ready. Request fields are registered at accept; inputs are then don't-care.
//    Legal request: IDLE->BEAT. Illegal request: IDLE->RESP directly with err=1 and no SRAM activity.
//    Illegal means: load funct3 in {011,110,111}; store funct3 >010; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//  Beats: byte/half ops = 1 beat at hw=addr[ADDR_W:1]. LW/SW = 2 beats at hw (low half), then hw+1 (high half).
//    Little-endian. hw+1 wraps modulo 2^ADDR_W (all-ones -> 0).
//    Beat counter 0..WAIT_CYCLES. Addr, LB/UB and DQ are stable for the whole beat.
//  Load beat: CE_N=0, OE_N=0, WE_N=1. DQ is sampled on the last cycle of the beat.
//  Store beat: CE_N=0, OE_N=1, WE_N=0 for all beat cycles; DQ driven.
//  Byte lanes:
//    Even byte -> LB_N=0, UB_N=1. Odd byte -> UB_N=0, LB_N=1. Half/word -> both 0.
//    SB drives {wdata[7:0],wdata[7:0]}. SH drives wdata[15:0]. SW beat0 drives wdata[15:0], beat1 drives wdata[31:16].
//  Load extension: LB/LH sign-extend from bit 7/15 of the selected lane; LBU/LHU zero-extend. LW = {beat1,beat0}.
//  Between beats, and in IDLE/RESP: all controls 1, DQ 'z, no gap cycle between beat0 and beat1.
//  RESP: exactly one cycle with o_rsp_valid=1; o_req_ready=0. Then IDLE. o_rsp_rdata/err clear to 0 when not valid.
//  Latency, accept edge -> o_rsp_valid high: beats*(WAIT_CYCLES+1)+1 cycles. Illegal request: 1 cycle.
//  Reset mid-operation: aborts immediately to the reset state. No response for the dropped request.
//  No request queueing: i_req_valid while busy is ignored until o_req_ready=1.
// STRUCTURE
//  Package riscv_mem_pkg: funct3 localparams (F3_LB..F3_SW); lsu_state_e {IDLE,BEAT,RESP}; extend function.
//  Sub-module sram_io_phy: registers the SRAM controls and address; owns the io_SRAM_DQ tristate and the read-sample register.
//  Top-level contains the FSM, beat/wait counters, lane select and extension.
// TESTING
//  1. WAIT=0: SW addr 0x100, wdata 0xDEADBEEF.
//     -> beat0 ADDR=0x080 DQ=0xBEEF; beat1 ADDR=0x081 DQ=0xDEAD; rsp_valid 3 cycles after accept, err=0.
//  2. WAIT=2: SRAM model holds 0x80 at odd byte 0x101.
//     LB 0x101 -> UB_N=0, rdata 0xFFFFFF80. LBU 0x101 -> rdata 0x00000080. Latency 4.
//  3. LW 0x1FFFFC with ADDR_W=20 (hw 0xFFFFE): second beat ADDR=0xFFFFF.
//     Also LW at byte 0x1FFFFE -> err=1, no CE_N activity, latency 1.
//  4. SH 0x003 and load funct3=011 -> both rsp_err=1, rdata 0, SRAM controls stay idle.
//  5. Reset asserted during beat1 of SW -> next cycle all controls high, DQ 'z.
//     No rsp_valid; the next LW completes normally.
//  6. i_req_valid held continuously with 4 mixed ops -> each accepted only when ready=1.
//     Exactly one rsp per request, in order.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared funct3 codes, FSM states and lane/extension helpers for the SRAM load/store path.
// Halfword lane order is little-endian; LW/SW are assembled from two beats.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} lsu_state_e;

  function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    if (we) bad_f3 = (f3 > F3_SW);
    else    bad_f3 = (f3 == 3'b011) || (f3[2:1] == 2'b11);
    case (f3[1:0])
      2'b01:   return bad_f3 | a[0];
      2'b10:   return bad_f3 | (a != 2'b00);
      default: return bad_f3;
    endcase
  endfunction

  // Active-low lane enables as {ub_n, lb_n}
  function automatic logic [1:0] lane_n(input logic [2:0] f3, input logic odd);
    if (f3[1:0] == 2'b00) return odd ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] store_lo(input logic [2:0] f3, input logic [31:0] w);
    if (f3[1:0] == 2'b00) return {w[7:0], w[7:0]};
    return w[15:0];
  endfunction

  function automatic logic [31:0] lsu_extend(input logic [2:0] f3, input logic odd, input logic [31:0] raw);
    logic [7:0] b;
    b = odd ? raw[15:8] : raw[7:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{raw[15]}}, raw[15:0]};
      F3_LW:   return raw;
      F3_LBU:  return {24'h0, b};
      F3_LHU:  return {16'h0, raw[15:0]};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/sram_io_phy.sv
// SRAM pin stage: registers controls/address one cycle ahead of use, owns the DQ tristate and read sample.
// Fixed one-cycle pipeline; no flow control, follows the controller every cycle.
module sram_io_phy #(
  parameter int ADDR_W  = 20,
  parameter int SRAM_DW = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_act,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [1:0]         i_lane_n,
  input  logic [SRAM_DW-1:0] i_wdat,
  input  logic               i_sample,
  output logic [SRAM_DW-1:0] o_rdat,
  output logic [ADDR_W-1:0]  o_SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  logic               dq_oe;
  logic [SRAM_DW-1:0] wdat_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_SRAM_CE_N <= 1'b1;
      o_SRAM_OE_N <= 1'b1;
      o_SRAM_WE_N <= 1'b1;
      o_SRAM_LB_N <= 1'b1;
      o_SRAM_UB_N <= 1'b1;
      o_SRAM_ADDR <= '0;
      dq_oe       <= 1'b0;
      wdat_q      <= '0;
      o_rdat      <= '0;
    end else begin
      o_SRAM_CE_N <= !i_act;
      o_SRAM_OE_N <= !(i_act && !i_we);
      o_SRAM_WE_N <= !(i_act && i_we);
      o_SRAM_LB_N <= i_act ? i_lane_n[0] : 1'b1;
      o_SRAM_UB_N <= i_act ? i_lane_n[1] : 1'b1;
      dq_oe       <= i_act && i_we;
      if (i_act) o_SRAM_ADDR <= i_addr;
      if (i_act && i_we) wdat_q <= i_wdat;
      if (i_sample) o_rdat <= io_SRAM_DQ;
    end
  end

  assign io_SRAM_DQ = dq_oe ? wdat_q : 'z;

endmodule

// File: rtl/sram_lsu_ctrl.sv
// RV32 load/store front-end to a 16-bit async SRAM: 1-2 beats of WAIT_CYCLES+1 cycles, then a one-cycle response.
// Latency beats*(WAIT_CYCLES+1)+1 (illegal: 1); ready only in IDLE, no queueing.
module sram_lsu_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int SRAM_DW     = 16,
  parameter int XLEN        = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [2:0]         i_req_funct3,
  input  logic [ADDR_W:0]    i_req_addr,
  input  logic [XLEN-1:0]    i_req_wdata,
  output logic               o_rsp_valid,
  output logic [XLEN-1:0]    o_rsp_rdata,
  output logic               o_rsp_err,
  output logic [ADDR_W-1:0]  o_SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  generate
    if (SRAM_DW != 16) begin : g_dw_chk
      $error("sram_lsu_ctrl: only SRAM_DW=16 is supported");
    end
    if (XLEN != 32) begin : g_xlen_chk
      $error("sram_lsu_ctrl: only XLEN=32 is supported");
    end
  endgenerate

  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(WAIT_CYCLES);

  lsu_state_e        state;
  logic [WCW-1:0]    wait_cnt;
  logic              beat_idx;
  logic              last_beat;
  logic              r_we;
  logic              r_odd;
  logic              r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_hw;
  logic [XLEN-1:0]   r_wdata;
  logic [15:0]       r_lo;

  logic              req_bad;
  logic              wait_done;
  logic              more_beats;
  logic              sample;
  logic              nx_act;
  logic              nx_we;
  logic              nx_hi;
  logic [1:0]        nx_lane_n;
  logic [ADDR_W-1:0] nx_addr;
  logic [15:0]       nx_wdat;
  logic [15:0]       phy_rdat;
  logic [31:0]       raw;

  assign req_bad    = req_illegal(i_req_we, i_req_funct3, i_req_addr[1:0]);
  assign wait_done  = (wait_cnt == WLAST);
  assign more_beats = (beat_idx != last_beat);
  assign sample     = (state == BEAT) && !r_we && wait_done;

  // Pin values for the next cycle; the PHY registers them so each beat lines up with the BEAT state.
  always_comb begin
    nx_act    = 1'b0;
    nx_we     = r_we;
    nx_hi     = 1'b0;
    nx_addr   = r_hw;
    nx_lane_n = 2'b11;
    nx_wdat   = store_lo(r_f3, r_wdata);
    if (state == IDLE && i_req_valid && !req_bad) begin
      nx_act    = 1'b1;
      nx_we     = i_req_we;
      nx_addr   = i_req_addr[ADDR_W:1];
      nx_lane_n = lane_n(i_req_funct3, i_req_addr[0]);
      nx_wdat   = store_lo(i_req_funct3, i_req_wdata);
    end else if (state == BEAT && (!wait_done || more_beats)) begin
      nx_act    = 1'b1;
      nx_hi     = beat_idx | wait_done;
      nx_addr   = nx_hi ? r_hw + ADDR_W'(1) : r_hw;
      nx_lane_n = lane_n(r_f3, r_odd);
      nx_wdat   = nx_hi ? r_wdata[31:16] : store_lo(r_f3, r_wdata);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      beat_idx  <= 1'b0;
      last_beat <= 1'b0;
      r_we      <= 1'b0;
      r_odd     <= 1'b0;
      r_err     <= 1'b0;
      r_f3      <= 3'b000;
      r_hw      <= '0;
      r_wdata   <= '0;
      r_lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            r_we      <= i_req_we;
            r_f3      <= i_req_funct3;
            r_odd     <= i_req_addr[0];
            r_hw      <= i_req_addr[ADDR_W:1];
            r_wdata   <= i_req_wdata;
            r_err     <= req_bad;
            wait_cnt  <= '0;
            beat_idx  <= 1'b0;
            last_beat <= (i_req_funct3[1:0] == 2'b10);
            state     <= req_bad ? RESP : BEAT;
          end
        end
        BEAT: begin
          // The PHY still holds beat 0 read data during the first cycle of beat 1.
          if (beat_idx && wait_cnt == '0) r_lo <= phy_rdat;
          if (wait_done) begin
            wait_cnt <= '0;
            if (more_beats) beat_idx <= 1'b1;
            else            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign raw         = last_beat ? {phy_rdat, r_lo} : {16'h0, phy_rdat};
  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_err   = (state == RESP) && r_err;
  assign o_rsp_rdata = (state == RESP && !r_err && !r_we) ? lsu_extend(r_f3, r_odd, raw) : '0;

  sram_io_phy #(
    .ADDR_W  (ADDR_W),
    .SRAM_DW (SRAM_DW)
  ) u_phy (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_act       (nx_act),
    .i_we        (nx_we),
    .i_addr      (nx_addr),
    .i_lane_n    (nx_lane_n),
    .i_wdat      (nx_wdat),
    .i_sample    (sample),
    .o_rdat      (phy_rdat),
    .o_SRAM_ADDR (o_SRAM_ADDR),
    .io_SRAM_DQ  (io_SRAM_DQ),
    .o_SRAM_CE_N (o_SRAM_CE_N),
    .o_SRAM_OE_N (o_SRAM_OE_N),
    .o_SRAM_WE_N (o_SRAM_WE_N),
    .o_SRAM_LB_N (o_SRAM_LB_N),
    .o_SRAM_UB_N (o_SRAM_UB_N)
  );

endmodule

// File: tb/tb_sram_lsu_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES 0 and 2), each with a small behavioural SRAM on its pins.
module tb_sram_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [20:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];
  logic [19:0] sram_addr [2];
  logic        ce_n [2];
  logic        oe_n [2];
  logic        we_n [2];
  logic        lb_n [2];
  logic        ub_n [2];
  wire  [15:0] dq0;
  wire  [15:0] dq1;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat;
  logic        got;
  logic        ce_seen;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [4:0]  log_ctl  [64];
  logic [19:0] log_addr [64];
  logic [15:0] log_dq   [64];

  always #5 clk = ~clk;

  sram_lsu_ctrl #(.ADDR_W(20), .SRAM_DW(16), .XLEN(32), .WAIT_CYCLES(0)) u_d0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
    .i_req_funct3(req_f3[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]),
    .o_SRAM_ADDR(sram_addr[0]), .io_SRAM_DQ(dq0),
    .o_SRAM_CE_N(ce_n[0]), .o_SRAM_OE_N(oe_n[0]), .o_SRAM_WE_N(we_n[0]),
    .o_SRAM_LB_N(lb_n[0]), .o_SRAM_UB_N(ub_n[0])
  );

  sram_lsu_ctrl #(.ADDR_W(20), .SRAM_DW(16), .XLEN(32), .WAIT_CYCLES(2)) u_d2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
    .i_req_funct3(req_f3[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]),
    .o_SRAM_ADDR(sram_addr[1]), .io_SRAM_DQ(dq1),
    .o_SRAM_CE_N(ce_n[1]), .o_SRAM_OE_N(oe_n[1]), .o_SRAM_WE_N(we_n[1]),
    .o_SRAM_LB_N(lb_n[1]), .o_SRAM_UB_N(ub_n[1])
  );

  // Behavioural SRAMs, indexed by the low 8 halfword address bits (test addresses do not alias)
  assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem0[sram_addr[0][7:0]] : 16'hzzzz;
  assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem1[sram_addr[1][7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n[0] && !we_n[0]) begin
      if (!lb_n[0]) mem0[sram_addr[0][7:0]][7:0]  <= dq0[7:0];
      if (!ub_n[0]) mem0[sram_addr[0][7:0]][15:8] <= dq0[15:8];
    end
    if (!ce_n[1] && !we_n[1]) begin
      if (!lb_n[1]) mem1[sram_addr[1][7:0]][7:0]  <= dq1[7:0];
      if (!ub_n[1]) mem1[sram_addr[1][7:0]][15:8] <= dq1[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ctl(input int d);
    return {ce_n[d], oe_n[d], we_n[d], lb_n[d], ub_n[d]};
  endfunction

  // One request; records pins per cycle after accept until the response (bounded).
  task automatic do_req(input string tag, input int d, input logic we, input logic [2:0] f3,
                        input logic [20:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_f3[d] = f3; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_f3[d] = 3'b011;
    req_addr[d] = 21'h1FFFFF; req_wdata[d] = 32'hFFFF_FFFF;
    lat = 0; got = 1'b0; ce_seen = 1'b0; r_rdata = 32'hx; r_err = 1'bx;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      log_ctl[lat]  = ctl(d);
      log_addr[lat] = sram_addr[d];
      log_dq[lat]   = (d == 0) ? dq0 : dq1;
      if (!ce_n[d]) ce_seen = 1'b1;
      if (rsp_valid[d]) begin
        got = 1'b1; r_rdata = rsp_rdata[d]; r_err = rsp_err[d];
      end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic        saw;
    logic        rdy;
    int          acc;
    int          nrsp;
    logic        op_we [4];
    logic [2:0]  op_f3 [4];
    logic [20:0] op_a  [4];
    logic [31:0] op_wd [4];
    logic [31:0] ex_rd [4];
    logic        ex_er [4];

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_f3[i] = 3'b000;
      req_addr[i] = '0; req_wdata[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0; mem1[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp", {rsp_valid[0], rsp_err[0], rsp_rdata[0][29:0]}, 32'd0);
    chk("rst_ctl", 32'(ctl(0)), 32'h1F);
    chk("rst_addr", 32'(sram_addr[0]), 32'd0);
    chk("rst_dq_oe", 32'(u_d0.u_phy.dq_oe), 32'd0);
    rst_n = 1'b1;

    // SW at 0x100, WAIT=0
    do_req("t1", 0, 1'b1, 3'b010, 21'h000100, 32'hDEADBEEF);
    chk("t1_lat", lat, 3);
    chk("t1_rsp", {r_err, r_rdata[30:0]}, 32'd0);
    chk("t1_b0_ctl", 32'(log_ctl[1]), 32'h08);
    chk("t1_b0_addr", 32'(log_addr[1]), 32'h080);
    chk("t1_b0_dq", 32'(log_dq[1]), 32'hBEEF);
    chk("t1_b1_ctl", 32'(log_ctl[2]), 32'h08);
    chk("t1_b1_addr", 32'(log_addr[2]), 32'h081);
    chk("t1_b1_dq", 32'(log_dq[2]), 32'hDEAD);
    chk("t1_resp_ctl", 32'(log_ctl[3]), 32'h1F);

    // WAIT=2: SB then LB/LBU at odd byte 0x101
    do_req("t2_sb", 1, 1'b1, 3'b000, 21'h000101, 32'h0000_0080);
    chk("t2_sb_lat", lat, 4);
    chk("t2_sb_ctl", 32'(log_ctl[3]), 32'h0A);
    chk("t2_sb_addr", 32'(log_addr[3]), 32'h080);
    chk("t2_sb_dq", 32'(log_dq[2]), 32'h8080);
    do_req("t2_lb", 1, 1'b0, 3'b000, 21'h000101, 32'h0);
    chk("t2_lb_lat", lat, 4);
    chk("t2_lb_ctl", 32'(log_ctl[1]), 32'h06);
    chk("t2_lb_rdata", r_rdata, 32'hFFFFFF80);
    do_req("t2_lbu", 1, 1'b0, 3'b100, 21'h000101, 32'h0);
    chk("t2_lbu_lat", lat, 4);
    chk("t2_lbu_rdata", r_rdata, 32'h00000080);

    // Top of the address space
    do_req("t3_sw", 0, 1'b1, 3'b010, 21'h1FFFFC, 32'h9ABC5678);
    do_req("t3_lw", 0, 1'b0, 3'b010, 21'h1FFFFC, 32'h0);
    chk("t3_lw_b0_addr", 32'(log_addr[1]), 32'hFFFFE);
    chk("t3_lw_b1_addr", 32'(log_addr[2]), 32'hFFFFF);
    chk("t3_lw_rdata", r_rdata, 32'h9ABC5678);
    chk("t3_lw_lat", lat, 3);
    do_req("t3_mis", 0, 1'b0, 3'b010, 21'h1FFFFE, 32'h0);
    chk("t3_mis_err", 32'(r_err), 32'd1);
    chk("t3_mis_lat", lat, 1);
    chk("t3_mis_ce", 32'(ce_seen), 32'd0);

    // Illegal requests
    do_req("t4_sh", 0, 1'b1, 3'b001, 21'h000003, 32'h1234);
    chk("t4_sh_rsp", {r_err, r_rdata[30:0]}, 32'h80000000);
    chk("t4_sh_ce", 32'(ce_seen), 32'd0);
    do_req("t4_f3", 0, 1'b0, 3'b011, 21'h000000, 32'h0);
    chk("t4_f3_rsp", {r_err, r_rdata[30:0]}, 32'h80000000);
    chk("t4_f3_lat", lat, 1);

    // Reset during beat 1 of a store
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_f3[0] = 3'b010;
    req_addr[0] = 21'h000040; req_wdata[0] = 32'h12345678;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_b0_addr", 32'(sram_addr[0]), 32'h020);
    @(negedge clk);
    chk("t5_b1_addr", 32'(sram_addr[0]), 32'h021);
    chk("t5_b1_we", 32'(we_n[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_ctl", 32'(ctl(0)), 32'h1F);
    chk("t5_rst_dq_oe", 32'(u_d0.u_phy.dq_oe), 32'd0);
    chk("t5_rst_ready", 32'(req_ready[0]), 32'd1);
    saw = rsp_valid[0];
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      saw = saw | rsp_valid[0];
    end
    chk("t5_no_rsp", 32'(saw), 32'd0);
    do_req("t5_lw", 0, 1'b0, 3'b010, 21'h000100, 32'h0);
    chk("t5_lw_rdata", r_rdata, 32'hDEADBEEF);
    chk("t5_lw_lat", lat, 3);

    // Back-to-back requests with valid held high
    op_we[0] = 1'b1; op_f3[0] = 3'b000; op_a[0] = 21'h105; op_wd[0] = 32'h0000_00A5; ex_rd[0] = 32'h0;        ex_er[0] = 1'b0;
    op_we[1] = 1'b0; op_f3[1] = 3'b100; op_a[1] = 21'h105; op_wd[1] = 32'h0;         ex_rd[1] = 32'h000000A5; ex_er[1] = 1'b0;
    op_we[2] = 1'b0; op_f3[2] = 3'b001; op_a[2] = 21'h100; op_wd[2] = 32'h0;         ex_rd[2] = 32'hFFFFBEEF; ex_er[2] = 1'b0;
    op_we[3] = 1'b1; op_f3[3] = 3'b010; op_a[3] = 21'h102; op_wd[3] = 32'h55AA55AA; ex_rd[3] = 32'h0;        ex_er[3] = 1'b1;
    acc = 0; nrsp = 0;
    for (int c = 0; c < 200 && nrsp < 4; c++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        chk($sformatf("t6_rdata%0d", nrsp), rsp_rdata[0], ex_rd[nrsp]);
        chk($sformatf("t6_err%0d", nrsp), 32'(rsp_err[0]), 32'(ex_er[nrsp]));
        chk($sformatf("t6_busy%0d", nrsp), 32'(req_ready[0]), 32'd0);
        nrsp++;
      end
      if (acc < 4) begin
        req_valid[0] = 1'b1; req_we[0] = op_we[acc]; req_f3[0] = op_f3[acc];
        req_addr[0] = op_a[acc]; req_wdata[0] = op_wd[acc];
      end else begin
        req_valid[0] = 1'b0;
      end
      rdy = req_ready[0];
      @(posedge clk);
      if (rdy && acc < 4) acc++;
    end
    req_valid[0] = 1'b0;
    chk("t6_accepted", acc, 4);
    chk("t6_responses", nrsp, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
